// File: rtl/cache_fill_fsm.sv
// ============================================================================
//  Module   : cache_fill_fsm
//  Brief    : Cache miss handler; fetches one block word-by-word from
//             pipelined memory, streams words into the data array, then
//             writes the tag/valid entry.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we,
  output logic [ADDR_W-1:0] block_addr,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int                BYTES    = DATA_W / 8;
  localparam int                OFF_W    = $clog2(WORDS * BYTES);
  localparam int                CNT_W    = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W-1:0] BYTES_A  = ADDR_W'(BYTES);
  localparam logic [CNT_W-1:0]  WORDS_C  = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] block_addr_q, block_addr_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      block_addr_q <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      block_addr_q <= block_addr_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    block_addr_d = block_addr_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    mem_en       = 1'b0;
    mem_addr     = '0;
    fill_we      = 1'b0;
    fill_idx     = '0;
    fill_data    = '0;
    tag_we       = 1'b0;
    fill_busy    = 1'b0;
    fill_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          block_addr_d = miss_addr & ~OFF_MASK;
          issue_cnt_d  = '0;
          ret_cnt_d    = '0;
          state_d      = S_FILL;
        end
      end

      S_FILL: begin
        fill_busy = 1'b1;
        if (issue_cnt_q < WORDS_C) begin
          mem_en   = 1'b1;
          mem_addr = block_addr_q + ADDR_W'(issue_cnt_q) * BYTES_A;
          if (mem_ready) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
          end
        end
        // Returns are written straight through in the same cycle they arrive.
        if (mem_valid && (ret_cnt_q < WORDS_C)) begin
          fill_we   = 1'b1;
          fill_idx  = ret_cnt_q[IDX_W-1:0];
          fill_data = mem_data;
          ret_cnt_d = ret_cnt_q + 1'b1;
          if (ret_cnt_q == LAST_C) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        fill_busy = 1'b1;
        tag_we    = 1'b1;
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign block_addr = block_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
//  Module   : tb_cache_fill_fsm
//  Brief    : Self-checking bench for cache_fill_fsm with a latency-L
//             memory model and an in-order fill scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cache_fill_fsm;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int IDX_W  = 3;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              rst, miss_req, mem_ready, mem_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_en, fill_we, tag_we, fill_busy, fill_done;
  logic [ADDR_W-1:0] mem_addr, block_addr;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .mem_en     (mem_en),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .fill_we    (fill_we),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data),
    .tag_we     (tag_we),
    .block_addr (block_addr),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  int checks   = 0;
  int failures = 0;
  int now      = 0;

  typedef struct {int due; logic [DATA_W-1:0] data;} ret_t;
  typedef struct {logic [IDX_W-1:0] idx; logic [DATA_W-1:0] data;} exp_t;
  ret_t pend[$];
  exp_t sb[$];
  int   done_q[$];

  int                m_state  = 0;
  int                m_issued = 0;
  int                m_ret    = 0;
  int                miss_cyc = 0;
  logic [ADDR_W-1:0] m_blk    = '0;

  typedef struct {
    logic r, mreq, rdy, mvalid;
    logic [ADDR_W-1:0] maddr;
    logic e_busy, e_en, e_we, e_tag;
    logic [ADDR_W-1:0] e_blk, e_maddr;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, act, exp, now);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic tick(input logic r, input logic rdy, input logic mreq, input logic [ADDR_W-1:0] maddr);
    logic exp_we, exp_en;
    exp_t e;
    ret_t p;
    @(posedge clk); #1;
    now++;
    rst = r; mem_ready = rdy; miss_req = mreq; miss_addr = maddr;
    if (pend.size() > 0 && pend[0].due == now) begin
      mem_valid = 1'b1;
      mem_data  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_data  = DATA_W'($urandom);
    end
    @(negedge clk);
    exp_we = (m_state == 1) && mem_valid && (m_ret < WORDS);
    exp_en = (m_state == 1) && (m_issued < WORDS);
    chk("fill_busy", fill_busy, m_state != 0);
    chk("mem_en", mem_en, exp_en);
    chk("tag_we", tag_we, m_state == 2);
    chk("fill_done", fill_done, m_state == 2);
    chk("block_addr", block_addr, m_blk);
    chk("fill_we", fill_we, exp_we);
    if (exp_en) chk("mem_addr", mem_addr, m_blk + ADDR_W'(m_issued * 2));
    if (fill_we && exp_we) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: got=fill_we expected=no write (cycle %0d)", now);
      end else begin
        e = sb.pop_front();
        chk("fill_idx", fill_idx, e.idx);
        chk("fill_data", fill_data, e.data);
      end
    end
    if (fill_done) done_q.push_back(now);
    // Memory answers whatever address the DUT actually requested.
    if (mem_en && mem_ready) begin
      p.due = now + LAT; p.data = mem_word(mem_addr);
      pend.push_back(p);
    end
    case (m_state)
      0: if (mreq) begin
        m_blk = maddr & 16'hFFF0; m_issued = 0; m_ret = 0; m_state = 1; miss_cyc = now;
      end
      1: begin
        if (exp_en && rdy) begin
          e.idx = IDX_W'(m_issued); e.data = mem_word(m_blk + ADDR_W'(m_issued * 2));
          sb.push_back(e);
          m_issued++;
        end
        if (exp_we) m_ret++;
        if (m_ret == WORDS) m_state = 2;
      end
      default: m_state = 0;
    endcase
    if (r) begin
      m_state = 0; m_blk = '0; sb.delete();
    end
  endtask

  task automatic check_done(input string nm, input int idx, input int exp_rel);
    if (done_q.size() > idx) chk(nm, done_q[idx] - miss_cyc, exp_rel);
    else chk(nm, 32'hFFFF_FFFF, exp_rel);
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; mem_ready = 1'b1; mem_valid = 1'b0; mem_data = '0;
    repeat (2) @(posedge clk);

    //         r  mreq rdy mv  maddr     busy en we tag blk      maddr
    vt[0] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[1] = '{1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[2] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[3] = '{1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[4] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[5] = '{1'b0,1'b1,1'b0,1'b0,16'h123A,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[6] = '{1'b0,1'b1,1'b0,1'b0,16'h5555,1'b1,1'b1,1'b0,1'b0,16'h1230,16'h1230};
    vt[7] = '{1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b0,1'b0,16'h1230,16'h1230};
    vt[8] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vt[9] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      now++;
      rst = vt[i].r; miss_req = vt[i].mreq; mem_ready = vt[i].rdy;
      mem_valid = vt[i].mvalid; miss_addr = vt[i].maddr; mem_data = 16'hBEEF;
      @(negedge clk);
      chk("vec_busy", fill_busy, vt[i].e_busy);
      chk("vec_mem_en", mem_en, vt[i].e_en);
      chk("vec_fill_we", fill_we, vt[i].e_we);
      chk("vec_tag_we", tag_we, vt[i].e_tag);
      chk("vec_fill_done", fill_done, vt[i].e_tag);
      chk("vec_block_addr", block_addr, vt[i].e_blk);
      chk("vec_mem_addr", mem_addr, vt[i].e_maddr);
    end

    // Basic fill, L=4, no back-pressure
    done_q.delete();
    tick(0, 1, 1, 16'h123A);
    for (int k = 1; k <= 16; k++) tick(0, 1, 0, 16'h0000);
    chk("s1_done_count", done_q.size(), 1);
    check_done("s1_done_rel", 0, 13);
    chk("s1_sb_empty", sb.size(), 0);

    // Back-pressure on request cycles 2 and 3
    done_q.delete();
    tick(0, 1, 1, 16'h0040);
    for (int k = 1; k <= 20; k++) tick(0, !(k == 2 || k == 3), 0, 16'h0000);
    check_done("s2_done_rel", 0, 15);
    chk("s2_sb_empty", sb.size(), 0);

    // Top-of-memory block with a miss_req mid-fill that must be ignored
    done_q.delete();
    tick(0, 1, 1, 16'hFFF6);
    for (int k = 1; k <= 16; k++) tick(0, 1, k == 5, 16'h2000);
    check_done("s3_done_rel", 0, 13);
    chk("s3_block_addr", block_addr, 16'hFFF0);

    // Reset after three returns, stale data then a clean fill
    done_q.delete();
    tick(0, 1, 1, 16'h0300);
    for (int k = 1; k <= 7; k++) tick(0, 1, 0, 16'h0000);
    tick(1, 1, 0, 16'h0000);
    for (int k = 9; k <= 16; k++) tick(0, 1, 0, 16'h0000);
    chk("s4_no_done", done_q.size(), 0);
    chk("s4_block_cleared", block_addr, 16'h0000);
    tick(0, 1, 1, 16'h0500);
    for (int k = 1; k <= 16; k++) tick(0, 1, 0, 16'h0000);
    check_done("s4_refill_done_rel", 0, 13);

    // miss_req held high: back-to-back fills
    done_q.delete();
    tick(0, 1, 1, 16'h0800);
    for (int k = 1; k <= 29; k++) tick(0, 1, 1, 16'h0800);
    for (int k = 0; k < 20; k++) tick(0, 1, 0, 16'h0000);
    chk("s5_done_count", done_q.size(), 3);
    if (done_q.size() >= 3) begin
      chk("s5_gap_1_2", done_q[1] - done_q[0], 14);
      chk("s5_gap_2_3", done_q[2] - done_q[1], 14);
    end
    chk("s5_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
